pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central stall scheduler for the 5-stage pipeline (PC/IF/ID/EX/MEM/WB).
- Detects load-use hazards between EX and ID and sequences the multi-cycle divide in EX with an internal cycle counter.
- Drives the shared `StallBus` that every stage register consumes.
- A stage register loads a bubble when its own stall bit is Stop and the next stage's bit is NoStop.

Parameters:
- LOAD_BUBBLES, 1, cycles ID is held behind a load whose destination it reads (1..3).
- DIV_CYCLES, 33, total EX occupancy of a div/divu including the issue cycle (2..63).
- CNT_W, 6, width of internal counters; must hold max(LOAD_BUBBLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction (ce from IF bus)
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_is_load  in  1  EX instruction is lb/lbu/lh/lhu/lw
- ex_rf_we  in  1  EX instruction writes regfile
- ex_rf_waddr  in  5  EX destination register
- ex_is_div  in  1  EX instruction is div/divu
- stall  out  `StallBus (6)  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop=1
- div_start  out  1  one-cycle pulse to the divider on EX entry of a divide
- div_done  out  1  one-cycle pulse in the last divide cycle; EX captures hi/lo
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: when rst=0 at a clock edge, state←IDLE and counters←0. Outputs are then: stall=6'b000000, div_start=0, div_done=0, busy=0. A reset mid-divide or mid-bubble aborts immediately; no pulse is emitted.
- Hazard term, combinational: hz = id_valid & ex_is_load & ex_rf_we & (ex_rf_waddr≠0) & ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
- States: IDLE, LOAD_HOLD, DIV_RUN.
- IDLE, ex_is_div=1:
  - div_start=1 this cycle.
  - stall=6'b001111 (PC..EX held; MEM receives a bubble).
  - cnt←DIV_CYCLES-2; next state DIV_RUN.
  - If DIV_CYCLES==2, go straight to the final cycle: div_done=1 in the next cycle.
- IDLE, hz=1 and ex_is_div=0:
  - stall=6'b000111 (EX receives a bubble).
  - If LOAD_BUBBLES==1, stay in IDLE.
  - Otherwise cnt←LOAD_BUBBLES-2 and next state LOAD_HOLD.
- IDLE, otherwise: stall=0.
- Priority: divide beats load-use in the same cycle.
- LOAD_HOLD:
  - stall=6'b000111.
  - If cnt==0, next state IDLE; else cnt←cnt-1.
  - The hazard is not re-evaluated while in LOAD_HOLD.
- DIV_RUN:
  - stall=6'b001111.
  - cnt decrements each cycle.
  - When cnt==0: div_done=1 and stall=6'b000000 in the same cycle, so the divide leaves EX on that edge; next state IDLE.
- Total divide occupancy: exactly DIV_CYCLES cycles, from the div_start cycle through the div_done cycle.
- Back-to-back divides: the following divide enters EX on the cycle after div_done, and IDLE issues a new div_start for it. No overlap is allowed.
- ex_is_div is ignored outside IDLE, so no re-trigger occurs while the divide is held in EX.
- $zero destination never causes a hazard.
- stall[4] and stall[5] are never asserted by this block.
- div_start and div_done are never high in the same cycle. Both are single-cycle pulses.
- busy = (state≠IDLE).
- All outputs are combinational from state, cnt and inputs. No output is registered beyond the FSM.

Decomposition:
- Shared package / lib/defines.vh:
  - `StallBus, `Stop, `NoStop.
  - Stall patterns STALL_NONE=6'b000000, STALL_LOADUSE=6'b000111, STALL_DIV=6'b001111.
  - State encodings for IDLE/LOAD_HOLD/DIV_RUN.
- One natural sub-module: hazard_detect, the combinational hz term, reusable for future hi/lo and mfc0 hazards.
- The FSM and counter stay in pipe_stall_ctrl.

Test Plan:
- Reset mid-divide:
  - Stimulus: div issued, rst=0 at cycle 10 of DIV_RUN.
  - Response: next cycle stall=0, busy=0, no div_done; a later div restarts a full 33-cycle count.
- Load-use on rs:
  - Stimulus: ex_is_load=1, ex_rf_we=1, ex_rf_waddr=5; id_rs=5, id_use_rs=1, id_valid=1.
  - Response: stall=6'b000111 for exactly 1 cycle (LOAD_BUBBLES=1), then 0.
- $zero and unused operand:
  - Stimulus A: same as load-use on rs, with ex_rf_waddr=0. Stimulus B: id_rt=5 with id_use_rt=0.
  - Response: stall stays 0 in both cases.
- Divide sequencing, DIV_CYCLES=33:
  - Stimulus: ex_is_div=1 in IDLE.
  - Response: div_start pulses in cycle 0; stall=6'b001111 for cycles 0..31; div_done=1 with stall=0 in cycle 32; busy high for cycles 1..32.
- Simultaneous divide and load hazard:
  - Stimulus: ex_is_div=1 and hz=1 in the same cycle.
  - Response: the DIV path is taken (stall=6'b001111, div_start=1), not LOAD_HOLD.
- Back-to-back divides plus LOAD_BUBBLES=3:
  - Stimulus: two consecutive divides.
  - Response: the second div_start occurs the cycle after the first div_done.
  - Separate run with LOAD_BUBBLES=3: a load hazard gives stall=6'b000111 for 3 consecutive cycles.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_pkg
// Description : Shared stall-bus types, stall patterns and FSM state
//               encodings for the pipeline stall scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;

    // One hold bit per stage register: bit0 PC .. bit5 WB
    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Load-use: PC/IF/ID held, EX takes a bubble
    localparam stall_bus_t STALL_NONE    = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP, NO_STOP};
    localparam stall_bus_t STALL_LOADUSE = {NO_STOP, NO_STOP, NO_STOP, STOP,    STOP,    STOP};
    // Divide: PC..EX held, MEM takes a bubble
    localparam stall_bus_t STALL_DIV     = {NO_STOP, NO_STOP, STOP,    STOP,    STOP,    STOP};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_HOLD = 2'd1,
        ST_DIV_RUN   = 2'd2
    } state_t;

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl_hazard_detect
// Description : Combinational load-use hazard term between the EX-stage load
//               and the ID-stage source operands. $zero never hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl_hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_is_load,
    input  logic       ex_rf_we,
    input  logic [4:0] ex_rf_waddr,
    output logic       hz
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_ex_loads_reg;

    // Raise the hazard when ID reads a register the EX load has not yet produced
    always_comb begin
        w_ex_loads_reg = ex_is_load & ex_rf_we & (ex_rf_waddr != 5'd0);
        w_rs_match     = id_use_rs & (id_rs == ex_rf_waddr);
        w_rt_match     = id_use_rt & (id_rt == ex_rf_waddr);
        hz             = id_valid & w_ex_loads_reg & (w_rs_match | w_rt_match);
    end

endmodule : pipe_stall_ctrl_hazard_detect
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Central stall scheduler. Holds ID behind load-use hazards and
//               keeps a divide in EX for DIV_CYCLES cycles, driving the
//               per-stage stall bus plus divider start/done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int DIV_CYCLES   = 33,
    parameter int CNT_W        = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               ex_is_load,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_rf_waddr,
    input  logic               ex_is_div,
    output logic [STALL_W-1:0] stall,
    output logic               div_start,
    output logic               div_done,
    output logic               busy
);

    // Counter preloads: the issue cycle in IDLE is the first of the
    // occupancy, and the counter reaching zero marks the final cycle.
    localparam logic [CNT_W-1:0] C_DIV_INIT  = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_LOAD_INIT = (LOAD_BUBBLES > 1) ? CNT_W'(LOAD_BUBBLES - 2) : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hz;

    pipe_stall_ctrl_hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_is_load  (ex_is_load),
        .ex_rf_we    (ex_rf_we),
        .ex_rf_waddr (ex_rf_waddr),
        .hz          (w_hz)
    );

    // State and cycle counter; divide wins over load-use when both arrive in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_is_div) begin
                        r_cnt   <= C_DIV_INIT;
                        r_state <= ST_DIV_RUN;
                    end else if (w_hz && (LOAD_BUBBLES > 1)) begin
                        r_cnt   <= C_LOAD_INIT;
                        r_state <= ST_LOAD_HOLD;
                    end
                end
                ST_LOAD_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stall bus and divider handshakes decoded from state, counter and inputs
    always_comb begin
        stall     = STALL_NONE;
        div_start = 1'b0;
        div_done  = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (ex_is_div) begin
                    stall     = STALL_DIV;
                    div_start = 1'b1;
                end else if (w_hz) begin
                    stall     = STALL_LOADUSE;
                end
            end
            ST_LOAD_HOLD: begin
                stall = STALL_LOADUSE;
            end
            ST_DIV_RUN: begin
                // Final cycle releases EX so the divide leaves on this edge
                if (r_cnt == '0) begin
                    div_done = 1'b1;
                end else begin
                    stall    = STALL_DIV;
                end
            end
            default: begin
                stall = STALL_NONE;
            end
        endcase
    end

endmodule : pipe_stall_ctrl
`default_nettype wire
